// File: rtl/bus_arbiter_ic.sv
`default_nettype none
// ============================================================================
// Module : bus_arbiter_ic
// Desc   : Two-master round-robin arbiter with a three-slave address decoder,
//          unmapped-address error response and slave response timeout.
// Rev    : 1.0  initial release
// ============================================================================
module bus_arbiter_ic #(
  parameter logic [31:0] S0_BASE = 32'h0000_0000,
  parameter logic [31:0] S0_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE = 32'h2000_0000,
  parameter logic [31:0] S1_MASK = 32'hFFFF_0000,
  parameter logic [31:0] S2_BASE = 32'h4000_0000,
  parameter logic [31:0] S2_MASK = 32'hFFFF_F000,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        bclk,
  input  logic        brst_n,
  // master 0
  input  logic        m0_breq,
  output logic        m0_bgnt,
  input  logic        m0_bstart,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_tsize,
  input  logic        m0_ttype,
  output logic [31:0] m0_rdata,
  output logic        m0_bdone,
  output logic        m0_berror,
  // master 1
  input  logic        m1_breq,
  output logic        m1_bgnt,
  input  logic        m1_bstart,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_tsize,
  input  logic        m1_ttype,
  output logic [31:0] m1_rdata,
  output logic        m1_bdone,
  output logic        m1_berror,
  // shared slave request
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [1:0]  s_tsize,
  output logic        s_ttype,
  // slave 0
  output logic        s0_ss,
  output logic        s0_bstart,
  input  logic [31:0] s0_rdata,
  input  logic        s0_bdone,
  input  logic        s0_berror,
  // slave 1
  output logic        s1_ss,
  output logic        s1_bstart,
  input  logic [31:0] s1_rdata,
  input  logic        s1_bdone,
  input  logic        s1_berror,
  // slave 2
  output logic        s2_ss,
  output logic        s2_bstart,
  input  logic [31:0] s2_rdata,
  input  logic        s2_bdone,
  input  logic        s2_berror
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_OWNED = 2'd1;
  localparam logic [1:0] c_BUSY  = 2'd2;
  localparam logic [1:0] c_ERR   = 2'd3;
  localparam logic [7:0] c_TMO   = TIMEOUT[7:0];

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  // Owner doubles as the round-robin pointer: the last master granted.
  logic        r_owner;
  logic [2:0]  r_sel;
  logic        r_sbstart;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_tsize;
  logic        r_ttype;

  logic        w_own_breq;
  logic        w_own_bstart;
  logic [31:0] w_own_addr;
  logic [31:0] w_own_wdata;
  logic [1:0]  w_own_tsize;
  logic        w_own_ttype;
  logic        w_win;
  logic [2:0]  w_dec;
  logic        w_slv_done;
  logic        w_slv_err;
  logic [31:0] w_slv_rdata;
  logic        w_tmo;
  logic        w_done;
  logic        w_err;
  logic [31:0] w_rdata;
  logic        w_owned;

  assign w_own_breq   = r_owner ? m1_breq   : m0_breq;
  assign w_own_bstart = r_owner ? m1_bstart : m0_bstart;
  assign w_own_addr   = r_owner ? m1_addr   : m0_addr;
  assign w_own_wdata  = r_owner ? m1_wdata  : m0_wdata;
  assign w_own_tsize  = r_owner ? m1_tsize  : m0_tsize;
  assign w_own_ttype  = r_owner ? m1_ttype  : m0_ttype;

  // On contention the master that did not own the bus last wins.
  assign w_win = (m0_breq && m1_breq) ? ~r_owner : m1_breq;

  always_comb begin
    w_dec = 3'b000;
    if ((w_own_addr & S0_MASK) == S0_BASE)      w_dec = 3'b001;
    else if ((w_own_addr & S1_MASK) == S1_BASE) w_dec = 3'b010;
    else if ((w_own_addr & S2_MASK) == S2_BASE) w_dec = 3'b100;
  end

  assign w_slv_done  = |(r_sel & {s2_bdone, s1_bdone, s0_bdone});
  assign w_slv_err   = |(r_sel & {s2_berror, s1_berror, s0_berror});
  assign w_slv_rdata = ({32{r_sel[0]}} & s0_rdata)
                     | ({32{r_sel[1]}} & s1_rdata)
                     | ({32{r_sel[2]}} & s2_rdata);
  assign w_tmo       = (r_state == c_BUSY) && (r_cnt == c_TMO);

  assign w_done  = (r_state == c_ERR) || ((r_state == c_BUSY) && (w_slv_done || w_tmo));
  assign w_err   = (r_state == c_ERR) || ((r_state == c_BUSY) && (w_slv_done ? w_slv_err : w_tmo));
  assign w_rdata = ((r_state == c_BUSY) && w_slv_done) ? w_slv_rdata : 32'h0;
  assign w_owned = (r_state != c_IDLE);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (m0_breq || m1_breq) w_state_nxt = c_OWNED;
      c_OWNED: begin
        if (!w_own_breq)       w_state_nxt = c_IDLE;
        else if (w_own_bstart) w_state_nxt = (|w_dec) ? c_BUSY : c_ERR;
      end
      c_BUSY:  if (w_slv_done || w_tmo) w_state_nxt = c_OWNED;
      c_ERR:   w_state_nxt = c_OWNED;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge bclk or negedge brst_n) begin
    if (!brst_n) begin
      r_state   <= c_IDLE;
      r_owner   <= 1'b1;
      r_sel     <= 3'b000;
      r_sbstart <= 1'b0;
      r_cnt     <= 8'd0;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_tsize   <= 2'd0;
      r_ttype   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sbstart <= 1'b0;
      case (r_state)
        c_IDLE: if (m0_breq || m1_breq) r_owner <= w_win;
        c_OWNED: begin
          if (w_own_breq && w_own_bstart) begin
            r_addr  <= w_own_addr;
            r_wdata <= w_own_wdata;
            r_tsize <= w_own_tsize;
            r_ttype <= w_own_ttype;
            if (|w_dec) begin
              r_sel     <= w_dec;
              r_sbstart <= 1'b1;
              r_cnt     <= 8'd0;
            end
          end
        end
        c_BUSY:  r_cnt <= r_cnt + 8'd1;
        default: ;
      endcase
    end
  end

  assign m0_bgnt   = w_owned && !r_owner;
  assign m1_bgnt   = w_owned &&  r_owner;
  assign m0_bdone  = w_done && !r_owner;
  assign m1_bdone  = w_done &&  r_owner;
  assign m0_berror = w_err  && !r_owner;
  assign m1_berror = w_err  &&  r_owner;
  assign m0_rdata  = r_owner ? 32'h0 : w_rdata;
  assign m1_rdata  = r_owner ? w_rdata : 32'h0;

  assign s_addr  = r_addr;
  assign s_wdata = r_wdata;
  assign s_tsize = r_tsize;
  assign s_ttype = r_ttype;

  // Select is held only while the transaction is outstanding.
  assign s0_ss     = (r_state == c_BUSY) && r_sel[0];
  assign s1_ss     = (r_state == c_BUSY) && r_sel[1];
  assign s2_ss     = (r_state == c_BUSY) && r_sel[2];
  assign s0_bstart = r_sbstart && r_sel[0];
  assign s1_bstart = r_sbstart && r_sel[1];
  assign s2_bstart = r_sbstart && r_sel[2];

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_ic.sv
`default_nettype none
// ============================================================================
// Module : tb_bus_arbiter_ic
// Desc   : Self-checking bench for bus_arbiter_ic: decode table, directed
//          corner sequences and randomized transactions against a model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bus_arbiter_ic;

  localparam int TMO = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  m_breq, m_bstart, m_ttype;
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic [1:0]  m_tsize [2];
  wire  [1:0]  m_bgnt, m_bdone, m_berror;
  wire  [31:0] m_rdata [2];
  wire  [31:0] s_addr, s_wdata;
  wire  [1:0]  s_tsize;
  wire         s_ttype;
  wire  [2:0]  s_ss, s_bst;
  logic [31:0] s_rdata [3];
  logic [2:0]  s_bdone, s_berror;

  bus_arbiter_ic #(.TIMEOUT(TMO)) dut (
    .bclk(clk), .brst_n(rst_n),
    .m0_breq(m_breq[0]), .m0_bgnt(m_bgnt[0]), .m0_bstart(m_bstart[0]),
    .m0_addr(m_addr[0]), .m0_wdata(m_wdata[0]), .m0_tsize(m_tsize[0]), .m0_ttype(m_ttype[0]),
    .m0_rdata(m_rdata[0]), .m0_bdone(m_bdone[0]), .m0_berror(m_berror[0]),
    .m1_breq(m_breq[1]), .m1_bgnt(m_bgnt[1]), .m1_bstart(m_bstart[1]),
    .m1_addr(m_addr[1]), .m1_wdata(m_wdata[1]), .m1_tsize(m_tsize[1]), .m1_ttype(m_ttype[1]),
    .m1_rdata(m_rdata[1]), .m1_bdone(m_bdone[1]), .m1_berror(m_berror[1]),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_tsize(s_tsize), .s_ttype(s_ttype),
    .s0_ss(s_ss[0]), .s0_bstart(s_bst[0]), .s0_rdata(s_rdata[0]), .s0_bdone(s_bdone[0]), .s0_berror(s_berror[0]),
    .s1_ss(s_ss[1]), .s1_bstart(s_bst[1]), .s1_rdata(s_rdata[1]), .s1_bdone(s_bdone[1]), .s1_berror(s_berror[1]),
    .s2_ss(s_ss[2]), .s2_bstart(s_bst[2]), .s2_rdata(s_rdata[2]), .s2_bdone(s_bdone[2]), .s2_berror(s_berror[2])
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_m_flags"}, {26'h0, m_bgnt, m_bdone, m_berror}, 32'h0);
    chk({name, "_m0_rdata"}, m_rdata[0], 32'h0);
    chk({name, "_m1_rdata"}, m_rdata[1], 32'h0);
    chk({name, "_s_sel"}, {26'h0, s_ss, s_bst}, 32'h0);
    chk({name, "_s_addr"}, s_addr, 32'h0);
    chk({name, "_s_wdata"}, s_wdata, 32'h0);
    chk({name, "_s_ctl"}, {29'h0, s_tsize, s_ttype}, 32'h0);
  endtask

  // Address map written as plain address ranges: 0 / 1 / 2 = slave, 3 = unmapped.
  function automatic int model_decode(input logic [31:0] a);
    if (a < 32'h0001_0000) return 0;
    if (a >= 32'h2000_0000 && a < 32'h2001_0000) return 1;
    if (a >= 32'h4000_0000 && a < 32'h4000_1000) return 2;
    return 3;
  endfunction

  // One transaction by owner m; es is the slave expected to be selected.
  task automatic do_txn(input int m, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] ts, input logic tt, input int lat,
                        input logic [31:0] rd, input logic be, input int es, input bit noise);
    int o = 1 - m;
    int ns = (es + 1) % 3;
    m_addr[m] = addr; m_wdata[m] = wd; m_tsize[m] = ts; m_ttype[m] = tt; m_bstart[m] = 1'b1;
    if (noise) begin
      m_bstart[o] = 1'b1;
      m_addr[o]   = ~addr;
    end
    tick();
    m_bstart = 2'b00;
    #1;
    chk("s_addr", s_addr, addr);
    chk("s_wdata", s_wdata, wd);
    chk("s_tsize_ttype", {29'h0, s_tsize, s_ttype}, {29'h0, ts, tt});
    if (es == 3) begin
      chk("miss_sel", {26'h0, s_ss, s_bst}, 32'h0);
      chk("miss_bdone_berror", {30'h0, m_bdone[m], m_berror[m]}, 32'h3);
      tick(); #1;
      chk("miss_after", {30'h0, m_bdone[m], m_bgnt[m]}, 32'h1);
    end else begin
      chk("hit_ss", {29'h0, s_ss}, 32'(1 << es));
      chk("hit_bstart", {29'h0, s_bst}, 32'(1 << es));
      for (int c = 0; c < lat; c++) begin
        if (noise && c == 1) begin
          m_bstart[m] = 1'b1;
          m_addr[m]   = ~addr;
          s_bdone[ns] = 1'b1;
          s_rdata[ns] = 32'hBAD0_0BAD;
        end
        #1;
        chk("busy_bdone", {30'h0, m_bdone}, 32'h0);
        if (c == 1) chk("busy_bstart_pulse", {29'h0, s_bst}, 32'h0);
        tick();
        m_bstart[m] = 1'b0;
        s_bdone[ns] = 1'b0;
        s_rdata[ns] = 32'h0;
      end
      s_bdone[es] = 1'b1; s_rdata[es] = rd; s_berror[es] = be;
      #1;
      chk("done_bdone", {30'h0, m_bdone[m], m_bdone[o]}, 32'h2);
      chk("done_rdata", m_rdata[m], rd);
      chk("done_berror", {31'h0, m_berror[m]}, {31'h0, be});
      chk("other_rdata", m_rdata[o], 32'h0);
      tick();
      s_bdone[es] = 1'b0; s_rdata[es] = 32'h0; s_berror[es] = 1'b0;
      #1;
      chk("after_ss", {29'h0, s_ss}, 32'h0);
      chk("after_gnt_bdone", {28'h0, m_bgnt[m], m_bgnt[o], m_bdone[m], m_bdone[o]}, 32'h8);
      chk("after_s_addr_kept", s_addr, addr);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  tsize;
    logic        ttype;
    logic [31:0] rdata;
    logic        berr;
    int          es;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int win, r, es, pick, lat;
    logic [31:0] a;
    bit early;
    int model_last;

    vecs[0] = '{32'h0000_0000, 32'h1111_0000, 2'd2, 1'b0, 32'hC0DE_0000, 1'b0, 0};
    vecs[1] = '{32'h0000_FFFC, 32'h1111_0001, 2'd1, 1'b1, 32'hC0DE_0001, 1'b0, 0};
    vecs[2] = '{32'h0001_0000, 32'h1111_0002, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 3};
    vecs[3] = '{32'h2000_0010, 32'h1111_0003, 2'd0, 1'b1, 32'hC0DE_0003, 1'b1, 1};
    vecs[4] = '{32'h2000_FFFF, 32'h1111_0004, 2'd0, 1'b0, 32'hC0DE_0004, 1'b0, 1};
    vecs[5] = '{32'h4000_0FFC, 32'h1111_0005, 2'd2, 1'b1, 32'hC0DE_0005, 1'b0, 2};
    vecs[6] = '{32'h4000_1000, 32'h1111_0006, 2'd2, 1'b0, 32'h0000_0000, 1'b0, 3};
    vecs[7] = '{32'hFFFF_FFFF, 32'h1111_0007, 2'd1, 1'b0, 32'h0000_0000, 1'b0, 3};
    vecs[8] = '{32'h1FFF_FFFC, 32'h1111_0008, 2'd2, 1'b1, 32'h0000_0000, 1'b0, 3};

    rst_n = 1'b0;
    m_breq = 2'b00; m_bstart = 2'b00; m_ttype = 2'b00;
    for (int i = 0; i < 2; i++) begin m_addr[i] = 0; m_wdata[i] = 0; m_tsize[i] = 0; end
    for (int i = 0; i < 3; i++) s_rdata[i] = 0;
    s_bdone = 3'b000; s_berror = 3'b000;
    repeat (3) tick();
    #1;
    chk_zero("reset");

    // Contention straight after reset: m0 first, then m1 after one idle cycle.
    m_breq = 2'b11; rst_n = 1'b1;
    tick(); #1;
    chk("cont_first_m0", {30'h0, m_bgnt}, 32'h1);
    m_breq[0] = 1'b0;
    tick(); #1;
    chk("cont_idle_gap", {30'h0, m_bgnt}, 32'h0);
    tick(); #1;
    chk("cont_then_m1", {30'h0, m_bgnt}, 32'h2);
    m_breq[1] = 1'b0;
    tick(); #1;
    chk("cont_idle2", {30'h0, m_bgnt}, 32'h0);
    m_breq = 2'b11;
    tick(); #1;
    chk("cont_rr_m0", {30'h0, m_bgnt}, 32'h1);
    m_breq[1] = 1'b0;

    // Decode table, m0 as owner throughout.
    for (int i = 0; i < 9; i++)
      do_txn(0, vecs[i].addr, vecs[i].wdata, vecs[i].tsize, vecs[i].ttype, 1,
             vecs[i].rdata, vecs[i].berr, vecs[i].es, 1'b0);

    // Single read with 3-cycle slave latency and bystander noise.
    do_txn(0, 32'h2000_0010, 32'h0, 2'd2, 1'b0, 3, 32'hDEAD_BEEF, 1'b0, 1, 1'b1);
    // Slave error on a byte write.
    do_txn(0, 32'h0000_0040, 32'h0000_00A5, 2'd0, 1'b1, 2, 32'h0, 1'b1, 0, 1'b0);

    m_breq[0] = 1'b0;
    tick(); #1;
    chk("release_m0", {30'h0, m_bgnt}, 32'h0);
    m_breq[1] = 1'b1;
    tick(); #1;
    chk("grant_m1", {30'h0, m_bgnt}, 32'h2);
    do_txn(1, 32'h8000_0000, 32'h5555_5555, 2'd2, 1'b1, 0, 32'h0, 1'b0, 3, 1'b0);
    m_breq[1] = 1'b0;
    tick();
    m_breq[0] = 1'b1;
    tick(); #1;
    chk("grant_m0_tmo", {30'h0, m_bgnt}, 32'h1);

    // Slave 2 never answers: error exactly TMO cycles after its bstart.
    m_addr[0] = 32'h4000_0004; m_bstart[0] = 1'b1;
    tick();
    m_bstart[0] = 1'b0;
    #1;
    chk("tmo_s2_bstart", {29'h0, s_bst}, 32'h4);
    early = (m_bdone != 2'b00);
    for (int k = 1; k < TMO; k++) begin
      tick(); #1;
      if (m_bdone != 2'b00) early = 1'b1;
    end
    chk("tmo_no_early_bdone", {31'h0, early}, 32'h0);
    tick(); #1;
    chk("tmo_bdone_berror", {30'h0, m_bdone[0], m_berror[0]}, 32'h3);
    tick(); #1;
    chk("tmo_ss_dropped", {29'h0, s_ss}, 32'h0);
    chk("tmo_grant_kept", {30'h0, m_bgnt}, 32'h1);
    s_bdone[2] = 1'b1; s_rdata[2] = 32'h1234_5678;
    #1;
    chk("tmo_late_ignored", {30'h0, m_bdone}, 32'h0);
    tick();
    s_bdone[2] = 1'b0; s_rdata[2] = 32'h0;

    // breq drop during BUSY takes effect after completion.
    m_addr[0] = 32'h2000_0000; m_bstart[0] = 1'b1;
    tick();
    m_bstart[0] = 1'b0; m_breq[0] = 1'b0;
    tick(); #1;
    chk("drop_busy_gnt", {30'h0, m_bgnt}, 32'h1);
    s_bdone[1] = 1'b1;
    #1;
    chk("drop_busy_done", {31'h0, m_bdone[0]}, 32'h1);
    tick();
    s_bdone[1] = 1'b0;
    #1;
    chk("drop_owned_gnt", {30'h0, m_bgnt}, 32'h1);
    tick(); #1;
    chk("drop_idle_gnt", {30'h0, m_bgnt}, 32'h0);

    // Asynchronous reset in the middle of a transaction.
    m_breq[0] = 1'b1;
    tick();
    m_addr[0] = 32'h2000_0100; m_wdata[0] = 32'hFEED_0001; m_bstart[0] = 1'b1;
    tick();
    m_bstart[0] = 1'b0;
    #1;
    chk("rst_busy_ss", {29'h0, s_ss}, 32'h2);
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick(); tick();
    m_breq = 2'b10; rst_n = 1'b1;
    #1;
    chk("rst_release_gnt", {30'h0, m_bgnt}, 32'h0);
    tick(); #1;
    chk("rst_m1_grant", {30'h0, m_bgnt}, 32'h2);
    m_breq = 2'b00;
    tick();

    // Randomized sessions against the transaction-level model.
    model_last = 1;
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(1, 3);
      m_breq = 2'(r);
      tick(); #1;
      if (r == 3) win = (model_last == 0) ? 1 : 0;
      else        win = (r == 2) ? 1 : 0;
      model_last = win;
      chk("rnd_grant", {30'h0, m_bgnt}, 32'(1 << win));
      m_breq[1 - win] = 1'b0;
      for (int t = 0; t < int'($urandom_range(1, 2)); t++) begin
        pick = $urandom_range(0, 3);
        case (pick)
          0:       a = {16'h0000, 16'($urandom)};
          1:       a = {16'h2000, 16'($urandom)};
          2:       a = {20'h40000, 12'($urandom)};
          default: a = $urandom;
        endcase
        es  = model_decode(a);
        lat = $urandom_range(0, 4);
        do_txn(win, a, $urandom, 2'($urandom_range(0, 2)), 1'($urandom), lat,
               $urandom, 1'($urandom), es, 1'($urandom));
      end
      m_breq[win] = 1'b0;
      tick(); #1;
      chk("rnd_release", {30'h0, m_bgnt}, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_arbiter_ic.md
BUS_ARBITER_IC -- requirements
Module: bus_arbiter_ic

Interface
REQ-001 Parameter S0_BASE, default 32'h0000_0000, base address of slave 0.
REQ-002 Parameter S0_MASK, default 32'hFFFF_0000, slave 0 decode mask; hit when (addr & MASK) == BASE.
REQ-003 Parameter S1_BASE, default 32'h2000_0000, base address of slave 1.
REQ-004 Parameter S1_MASK, default 32'hFFFF_0000, slave 1 decode mask.
REQ-005 Parameter S2_BASE, default 32'h4000_0000, base address of slave 2.
REQ-006 Parameter S2_MASK, default 32'hFFFF_F000, slave 2 decode mask.
REQ-007 Parameter TIMEOUT, default 255, maximum cycles from slave bstart to slave bdone.
REQ-008 Ports SHALL be exactly as listed below; X is master 0..1, Y is slave 0..2.
REQ-009 bclk  input  1  bus clock; the block has one clock.
REQ-010 brst_n  input  1  asynchronous, active-low reset.
REQ-011 mX_breq  input  1  master X bus request.
REQ-012 mX_bgnt  output  1  master X owns the bus.
REQ-013 mX_bstart  input  1  one-cycle transaction start pulse from master X.
REQ-014 mX_addr  input  32  master X address.
REQ-015 mX_wdata  input  32  master X write data.
REQ-016 mX_tsize  input  2  tsize_e: BYTE=0, HALFWORD=1, WORD=2.
REQ-017 mX_ttype  input  1  ttype_e: READ=0, WRITE=1.
REQ-018 mX_rdata  output  32  read data returned to master X.
REQ-019 mX_bdone  output  1  one-cycle completion pulse to master X.
REQ-020 mX_berror  output  1  error qualifier; valid only with mX_bdone.
REQ-021 s_addr, s_wdata, s_tsize, s_ttype  output  32/32/2/1  registered request fields, shared by all slaves.
REQ-022 sY_ss  output  1  slave Y select; held high for the whole transaction.
REQ-023 sY_bstart  output  1  one-cycle start pulse to slave Y.
REQ-024 sY_rdata, sY_bdone, sY_berror  input  32/1/1  slave Y response.

Function
REQ-025 The FSM SHALL have the states IDLE, OWNED, BUSY and ERR.
REQ-026 In IDLE with any breq, the block SHALL grant a master and go to OWNED; mX_bgnt rises on the next edge.
REQ-027 Arbitration SHALL be round-robin: when both masters request, the master not granted last wins; after reset, master 0 has priority.
REQ-028 While in OWNED, the grant SHALL hold while the owner keeps breq high; no preemption occurs.
REQ-029 When the owner drops breq in OWNED, the block SHALL drop bgnt the next cycle and return to IDLE; re-arbitration takes at least one IDLE cycle.
REQ-030 When the owner pulses bstart in OWNED, the block SHALL register addr, wdata, tsize and ttype onto s_*.
REQ-031 On that same owner bstart, if the address hits a slave, the block SHALL assert sY_ss and a one-cycle sY_bstart on the next cycle and enter BUSY.
REQ-032 Decode priority on overlap SHALL be S0 > S1 > S2.
REQ-033 An address that hits no slave SHALL enter ERR; mX_bdone=1 and mX_berror=1 the next cycle, with no ss or bstart.
REQ-034 From ERR, the block SHALL return to OWNED.
REQ-035 In BUSY, on sY_bdone the block SHALL drive mX_bdone=1, mX_rdata=sY_rdata and mX_berror=sY_berror combinationally in the same cycle.
REQ-036 On the cycle after sY_bdone, the block SHALL deassert ss and return to OWNED.
REQ-037 The BUSY timeout counter is 8 bits wide, clears at slave bstart and increments each cycle.
REQ-038 When the timeout count reaches TIMEOUT, the block SHALL drive mX_bdone=1 and mX_berror=1, drop ss and go to OWNED.
REQ-039 A late slave bdone after a timeout SHALL be ignored.
REQ-040 bstart from a non-owner, or owner bstart outside OWNED, SHALL be ignored.
REQ-041 A breq drop while in BUSY SHALL take effect only after completion.
REQ-042 The non-granted master SHALL see bgnt=0, bdone=0, berror=0 and rdata=0.
REQ-043 A slave not selected SHALL have its sY_bdone ignored.

Reset
REQ-044 While brst_n=0, all outputs SHALL be 0, the FSM in IDLE, the round-robin pointer set to favour master 0, and the counter at 0; reset asynchronously aborts any transaction.
REQ-045 Reset release SHALL be sampled on bclk; the first grant is possible one cycle after release.

Verification
REQ-046 Single read: m0 requests and pulses bstart with addr 0x2000_0010, READ, WORD; s1 bdone after 3 cycles with rdata 0xDEAD_BEEF -> s1_ss/s1_bstart asserted, m0_bdone=1, m0_rdata=0xDEAD_BEEF, m0_berror=0.
REQ-047 Contention: m0 and m1 request together after reset -> m0 granted; m0 drops breq -> one IDLE cycle, then m1_bgnt=1; next simultaneous request grants m0.
REQ-048 Unmapped address: m1 bstart to addr 0x8000_0000 -> no ss, m1_bdone=1 and m1_berror=1 on the next cycle, grant retained.
REQ-049 Timeout: s2 never responds to addr 0x4000_0004 -> m0_bdone=1 and m0_berror=1 exactly TIMEOUT cycles after s2_bstart; a later s2_bdone produces no m0_bdone.
REQ-050 Reset mid-transaction: brst_n=0 while in BUSY -> all outputs 0 immediately; after release, m1 alone requesting is granted.
REQ-051 Slave error: s0 returns bdone with berror=1 for a WRITE with tsize BYTE -> m0_berror=1 with m0_bdone, and the grant is retained.
